// File: rtl/disp_vramrd.sv
// VRAM burst-read engine: walks a rectangular frame (line length, count, stride)
// as fixed-length AXI read bursts with a bounded number of bursts in flight.
module disp_vramrd #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned BURST_LEN = 32,
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned HB_W      = 12,
    parameter int unsigned VL_W      = 11
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic              START,
    input  logic              DISPON,
    input  logic [ADDR_W-1:0] BASEADDR,
    input  logic [ADDR_W-1:0] STRIDE,
    input  logic [HB_W-1:0]   LINE_BEATS,
    input  logic [VL_W-1:0]   LINES,
    input  logic              BUF_WREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic              RVALID,
    input  logic              RLAST,
    input  logic [1:0]        RRESP,
    output logic              RREADY,
    output logic              BUSY,
    output logic              DONE,
    output logic              RERR,
    output logic              OVERRUN
);

    localparam int unsigned BL_LOG2 = $clog2(BURST_LEN);
    localparam int unsigned OC_W    = 4;
    localparam logic [ADDR_W-1:0] BB   = ADDR_W'(BURST_LEN * DATA_W / 8);
    localparam logic [OC_W:0]     MAXO = (OC_W + 1)'(MAX_OUTST);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   stride_q, line_start, cur_addr;
    logic [HB_W-1:0]     bpl_q, bcnt;
    logic [VL_W-1:0]     lines_q, lcnt;
    logic [OC_W-1:0]     outst, outst_nxt;

    logic                start_acc, frame_empty, ar_hs, ar_pend, r_last, remain, room;
    logic                use_in, last_in_line, issue;
    logic                arvalid_nxt, done_nxt, busy_nxt, rerr_nxt, ovr_nxt;
    logic [HB_W-1:0]     bpl_in, src_bpl, src_bcnt;
    logic [VL_W-1:0]     src_lcnt;
    logic [ADDR_W-1:0]   src_addr, src_line, src_stride;

    assign ARLEN = 8'(BURST_LEN - 1);

    // In IDLE a frame-start issues its first burst straight from the register inputs
    assign bpl_in       = HB_W'(LINE_BEATS >> BL_LOG2);
    assign start_acc    = (state == S_IDLE) && START && DISPON;
    assign frame_empty  = (bpl_in == '0) || (LINES == '0);
    assign use_in       = (state == S_IDLE);
    assign src_addr     = use_in ? BASEADDR : cur_addr;
    assign src_line     = use_in ? BASEADDR : line_start;
    assign src_stride   = use_in ? STRIDE   : stride_q;
    assign src_bpl      = use_in ? bpl_in   : bpl_q;
    assign src_bcnt     = use_in ? '0       : bcnt;
    assign src_lcnt     = use_in ? '0       : lcnt;
    assign last_in_line = (src_bcnt == src_bpl - HB_W'(1));
    assign remain       = use_in ? (start_acc && !frame_empty) : (lcnt != lines_q);

    assign ar_hs   = ARVALID && ARREADY;
    assign ar_pend = ARVALID && !ARREADY;
    assign r_last  = RVALID && RREADY && RLAST && (outst != '0);
    // A burst on the AR bus already counts against the limit, accepted or not
    assign room    = (({1'b0, outst} + (OC_W + 1)'(ARVALID)) < MAXO);

    always_comb begin
        outst_nxt = outst;
        if (ar_hs && !r_last)
            outst_nxt = outst + OC_W'(1);
        else if (!ar_hs && r_last)
            outst_nxt = outst - OC_W'(1);
    end

    always_ff @(posedge ACLK) begin
        if (ARST) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_acc && !frame_empty) state_nxt = S_RUN;
            S_RUN:   if (!ar_pend && (!DISPON || !remain)) state_nxt = S_DRAIN;
            S_DRAIN: if (outst_nxt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        issue       = 1'b0;
        arvalid_nxt = ar_pend;
        done_nxt    = 1'b0;
        busy_nxt    = (state_nxt != S_IDLE);
        rerr_nxt    = start_acc ? 1'b0 : RERR;
        ovr_nxt     = start_acc ? 1'b0 : (OVERRUN || (START && BUSY));
        if ((state == S_RUN || start_acc) && DISPON && BUF_WREADY && room && remain && !ar_pend)
            issue = 1'b1;
        if (issue)
            arvalid_nxt = 1'b1;
        if ((state == S_DRAIN && outst_nxt == '0) || (start_acc && frame_empty))
            done_nxt = 1'b1;
        if (RVALID && RREADY && (RRESP != 2'b00))
            rerr_nxt = 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            ARVALID    <= 1'b0;
            ARADDR     <= '0;
            RREADY     <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            RERR       <= 1'b0;
            OVERRUN    <= 1'b0;
            outst      <= '0;
            bcnt       <= '0;
            lcnt       <= '0;
            stride_q   <= '0;
            bpl_q      <= '0;
            lines_q    <= '0;
            line_start <= '0;
            cur_addr   <= '0;
        end else begin
            ARVALID <= arvalid_nxt;
            RREADY  <= 1'b1;
            BUSY    <= busy_nxt;
            DONE    <= done_nxt;
            RERR    <= rerr_nxt;
            OVERRUN <= ovr_nxt;
            outst   <= outst_nxt;
            if (start_acc) begin
                stride_q   <= STRIDE;
                bpl_q      <= bpl_in;
                lines_q    <= LINES;
                line_start <= BASEADDR;
                cur_addr   <= BASEADDR;
                bcnt       <= '0;
                lcnt       <= '0;
            end
            // Advance the walk at issue time; cur_addr always holds the next burst
            if (issue) begin
                ARADDR <= src_addr;
                if (last_in_line) begin
                    bcnt       <= '0;
                    lcnt       <= src_lcnt + VL_W'(1);
                    line_start <= src_line + src_stride;
                    cur_addr   <= src_line + src_stride;
                end else begin
                    bcnt     <= src_bcnt + HB_W'(1);
                    cur_addr <= src_addr + BB;
                end
            end
        end
    end

endmodule

// File: tb/tb_disp_vramrd.sv
// Directed plus randomized frames against a queue-based model of the frame walk
// and an AXI read slave with configurable acceptance and response latency.
module tb_disp_vramrd;

    localparam int BL    = 32;
    localparam int DW    = 64;
    localparam int MAX_O = 2;
    localparam int BB    = BL * DW / 8;

    logic        ACLK = 1'b0;
    logic        ARST, START, DISPON, BUF_WREADY, ARREADY, RVALID, RLAST;
    logic [31:0] BASEADDR, STRIDE, ARADDR;
    logic [11:0] LINE_BEATS;
    logic [10:0] LINES;
    logic [1:0]  RRESP;
    logic [7:0]  ARLEN;
    logic        ARVALID, RREADY, BUSY, DONE, RERR, OVERRUN;

    always #5 ACLK = ~ACLK;

    disp_vramrd #(
        .ADDR_W(32), .DATA_W(DW), .BURST_LEN(BL), .MAX_OUTST(MAX_O), .HB_W(12), .VL_W(11)
    ) dut (
        .ACLK(ACLK), .ARST(ARST), .START(START), .DISPON(DISPON),
        .BASEADDR(BASEADDR), .STRIDE(STRIDE), .LINE_BEATS(LINE_BEATS), .LINES(LINES),
        .BUF_WREADY(BUF_WREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID),
        .ARREADY(ARREADY), .RVALID(RVALID), .RLAST(RLAST), .RRESP(RRESP), .RREADY(RREADY),
        .BUSY(BUSY), .DONE(DONE), .RERR(RERR), .OVERRUN(OVERRUN)
    );

    int          n_tests = 0, n_fail = 0, cyc = 0;
    logic [31:0] exp_q[$];
    int          rq[$];
    int          model_outst = 0, issued = 0, cur_beat = 0, beat_idx = 0, err_beat = -1;
    int          drop_after = 0, done_cnt = 0, done_cyc = 0, last_rlast_cyc = 0;
    int          ar_prob = 100, bw_prob = 100, rdly_min = 0, rdly_max = 0, ar_low = 0;
    int          start_cyc = 0, exp_n = 0;
    bit          bw_toggle = 0, prev_pend = 0, prev_gate = 0;
    logic [31:0] prev_addr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: play the AXI slave, update the model, step, then observe
    task automatic tick();
        if (ar_low > 0) begin ARREADY = 1'b0; ar_low--; end
        else ARREADY = ($urandom_range(0, 99) < ar_prob);
        if (bw_toggle) BUF_WREADY = ~BUF_WREADY;
        else BUF_WREADY = ($urandom_range(0, 99) < bw_prob);
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        if (!ARST) begin
            if (rq.size() > 0 && rq[0] <= cyc && RREADY === 1'b1 && $urandom_range(0, 9) != 0) begin
                RVALID = 1'b1;
                if (beat_idx == err_beat) RRESP = 2'b10;
                beat_idx++;
                cur_beat++;
                if (cur_beat == BL) begin
                    RLAST = 1'b1; cur_beat = 0;
                    void'(rq.pop_front());
                    model_outst--;
                    last_rlast_cyc = cyc;
                end
            end
            if (ARVALID === 1'b1 && ARREADY) begin
                if (exp_q.size() > 0) chk("araddr", 64'(ARADDR), 64'(exp_q.pop_front()));
                chk("arlen", 64'(ARLEN), 64'(BL - 1));
                issued++;
                model_outst++;
                chk("outst_limit", 64'(model_outst <= MAX_O), 64'(1));
                rq.push_back(cyc + 1 + int'($urandom_range(rdly_min, rdly_max)));
                if (drop_after > 0 && issued == drop_after) DISPON = 1'b0;
            end
        end
        prev_pend = !ARST && ARVALID === 1'b1 && !ARREADY;
        prev_addr = ARADDR;
        prev_gate = BUF_WREADY && DISPON;
        @(posedge ACLK);
        #1;
        cyc++;
        if (!ARST) begin
            if (DONE) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_low_at_done", 64'(BUSY), 64'(0));
            end
            if (prev_pend) begin
                chk("ar_hold_valid", 64'(ARVALID), 64'(1));
                chk("ar_hold_addr", 64'(ARADDR), 64'(prev_addr));
            end else if (ARVALID) begin
                chk("ar_issue_gate", 64'(prev_gate), 64'(1));
                chk("ar_room", 64'(model_outst < MAX_O), 64'(1));
            end
        end
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [31:0] stride,
                               input int lb, input int lines, input int dropa, input int errb);
        int bpl, total;
        bpl   = lb / BL;
        total = bpl * lines;
        exp_q.delete();
        for (int j = 0; j < lines; j++)
            for (int k = 0; k < bpl; k++)
                exp_q.push_back(base + 32'(j) * stride + 32'(k * BB));
        exp_n = (dropa > 0 && dropa < total) ? dropa : total;
        while (exp_q.size() > exp_n) void'(exp_q.pop_back());
        issued = 0; done_cnt = 0; beat_idx = 0; cur_beat = 0;
        err_beat = errb; drop_after = dropa;
        BASEADDR = base; STRIDE = stride; LINE_BEATS = 12'(lb); LINES = 11'(lines);
        DISPON = 1'b1; START = 1'b1;
        start_cyc = cyc;
        tick();
        START = 1'b0;
        chk("rerr_cleared", 64'(RERR), 64'(0));
        chk("overrun_cleared", 64'(OVERRUN), 64'(0));
        if (total > 0) chk("busy_at_start", 64'(BUSY), 64'(1));
        else begin
            chk("done_empty_frame", 64'(DONE), 64'(1));
            chk("busy_empty_frame", 64'(BUSY), 64'(0));
        end
    endtask

    task automatic finish_frame(input int ovr_at);
        bit exp_rerr;
        for (int n = 0; n < 20000 && done_cnt == 0; n++) begin
            if (n == ovr_at) begin START = 1'b1; BASEADDR = 32'hDEAD_0000; end
            tick();
            if (n == ovr_at) begin
                START = 1'b0;
                chk("overrun_set", 64'(OVERRUN), 64'(1));
            end
        end
        chk("frame_done", 64'(done_cnt), 64'(1));
        if (exp_n > 0) chk("done_timing", 64'(done_cyc), 64'(last_rlast_cyc + 1));
        else           chk("done_timing_empty", 64'(done_cyc), 64'(start_cyc + 1));
        chk("ar_count", 64'(issued), 64'(exp_n));
        chk("outst_zero", 64'(model_outst), 64'(0));
        repeat (3) tick();
        exp_rerr = (err_beat >= 0) && (err_beat < exp_n * BL);
        chk("done_once", 64'(done_cnt), 64'(1));
        chk("busy_idle", 64'(BUSY), 64'(0));
        chk("rerr_sticky", 64'(RERR), 64'(exp_rerr));
        if (ovr_at >= 0) chk("overrun_sticky", 64'(OVERRUN), 64'(1));
        DISPON = 1'b1;
    endtask

    initial begin
        bit hit;
        ARST = 1'b1; START = 1'b0; DISPON = 1'b0; BUF_WREADY = 1'b1; ARREADY = 1'b0;
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
        BASEADDR = '0; STRIDE = '0; LINE_BEATS = '0; LINES = '0;
        repeat (2) tick();
        chk("rst_arvalid", 64'(ARVALID), 64'(0));
        chk("rst_araddr", 64'(ARADDR), 64'(0));
        chk("rst_rready", 64'(RREADY), 64'(0));
        chk("rst_busy", 64'(BUSY), 64'(0));
        chk("rst_done", 64'(DONE), 64'(0));
        chk("rst_rerr", 64'(RERR), 64'(0));
        chk("rst_overrun", 64'(OVERRUN), 64'(0));
        ARST = 1'b0;
        tick();
        chk("rready_after_rst", 64'(RREADY), 64'(1));

        // START without DISPON is ignored
        done_cnt = 0;
        BASEADDR = 32'h1000; STRIDE = 32'h400; LINE_BEATS = 12'd64; LINES = 11'd2;
        DISPON = 1'b0; START = 1'b1;
        tick();
        START = 1'b0;
        chk("nodispon_busy", 64'(BUSY), 64'(0));
        chk("nodispon_arvalid", 64'(ARVALID), 64'(0));
        repeat (4) tick();
        chk("nodispon_done", 64'(done_cnt), 64'(0));

        // Basic frame: 0x1000, 0x1100, 0x1400, 0x1500
        start_frame(32'h1000, 32'h400, 64, 2, 0, -1);
        chk("basic_first_arvalid", 64'(ARVALID), 64'(1));
        chk("basic_first_araddr", 64'(ARADDR), 64'h1000);
        finish_frame(-1);

        // Outstanding limit with slow responses
        rdly_min = 50; rdly_max = 50;
        start_frame(32'h0002_0000, 32'h1000, 128, 2, 0, -1);
        finish_frame(-1);

        // AR back-pressure with toggling buffer-ready
        rdly_min = 0; rdly_max = 4; ar_low = 10; bw_toggle = 1;
        start_frame(32'h4000, 32'h300, 96, 2, 0, -1);
        finish_frame(-1);
        bw_toggle = 0;

        // DISPON drops after two of four bursts
        rdly_min = 5; rdly_max = 10;
        start_frame(32'h9000, 32'h200, 64, 2, 2, -1);
        finish_frame(-1);

        // START while busy
        rdly_min = 0; rdly_max = 3;
        start_frame(32'h3000, 32'h100, 64, 2, 0, -1);
        finish_frame(3);

        // Error response, then degenerate frames clear it
        start_frame(32'h5000, 32'h400, 32, 3, 0, 40);
        finish_frame(-1);
        start_frame(32'h6000, 32'h400, 16, 2, 0, -1);
        finish_frame(-1);
        start_frame(32'h6000, 32'h400, 64, 0, 0, -1);
        finish_frame(-1);

        // Reset mid-frame with a burst on the bus and one outstanding
        rdly_min = 50; rdly_max = 50;
        start_frame(32'h8000, 32'h800, 96, 3, 0, -1);
        hit = 0;
        for (int n = 0; n < 300 && !hit; n++) begin
            if (ARVALID && model_outst == MAX_O - 1) hit = 1;
            else tick();
        end
        chk("reset_setup_reached", 64'(hit), 64'(1));
        ARST = 1'b1;
        tick();
        chk("mrst_arvalid", 64'(ARVALID), 64'(0));
        chk("mrst_araddr", 64'(ARADDR), 64'(0));
        chk("mrst_rready", 64'(RREADY), 64'(0));
        chk("mrst_busy", 64'(BUSY), 64'(0));
        chk("mrst_done", 64'(DONE), 64'(0));
        ARST = 1'b0;
        rq.delete(); model_outst = 0; cur_beat = 0;
        tick();
        chk("mrst_rready_back", 64'(RREADY), 64'(1));
        rdly_min = 0; rdly_max = 2;
        start_frame(32'h0001_0000, 32'h600, 96, 2, 0, -1);
        finish_frame(-1);

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            ar_prob  = int'($urandom_range(40, 100));
            bw_prob  = int'($urandom_range(50, 100));
            rdly_min = 0;
            rdly_max = int'($urandom_range(0, 8));
            start_frame($urandom & 32'hFFFF_FF00, 32'($urandom_range(0, 32'h3000)),
                        int'($urandom_range(0, 130)), int'($urandom_range(0, 3)), 0,
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 200)) : -1);
            finish_frame(-1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
